// File: rtl/garegga_sound_cmd_mailbox.sv
// Sound-command mailbox between the 68000 and the sound Z80: command queue, Z80 IRQ handshake and 68k WAIT.
// Define GAREGGA_SNDCMD_FIFO_EN for a DEPTH-entry FIFO; otherwise a single-entry latch is built.
module garegga_sound_cmd_mailbox #(
  parameter int DEPTH = 4
) (
  input  logic       CLK96,
  input  logic       RESET96_N,
  input  logic       CMD_WE,
  input  logic [7:0] CMD_DIN,
  output logic       CMD_BUSY,
  output logic       OVERRUN,
  input  logic       LATCH_RD,
  output logic [7:0] SOUNDLATCH,
  input  logic       ACK_WR,
  input  logic       INTACK,
  output logic       Z80INT_N,
  output logic [4:0] PENDING
);

`ifdef GAREGGA_SNDCMD_FIFO_EN
  localparam int CAP = DEPTH;
  localparam int PW  = $clog2(DEPTH);
`else
  // DEPTH is accepted so both builds share one port/parameter list; the latch holds one byte.
  localparam int CAP = 1 + 0 * DEPTH;
`endif
  localparam logic [4:0] CAP5 = 5'(CAP);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } irq_st_e;

  irq_st_e    st_q, st_d;
  logic [4:0] count_q, count_d;
  logic       busy_q, ovr_q, int_n_q;
  logic [7:0] latch_q, latch_d;
  logic [7:0] head_d;
  logic       full_s, push_s, drop_s, pop_s;
  logic       unused_latch_rd;

  // The Z80 latch read is non-destructive, so the strobe carries no state.
  assign unused_latch_rd = LATCH_RD;

  // Push admission is judged on the registered count only.
  always_comb begin
    full_s = (count_q == CAP5);
    push_s = CMD_WE & ~full_s;
    drop_s = CMD_WE & full_s;
  end

  // IRQ handshake next-state; an acknowledge is the only source of a pop.
  always_comb begin
    st_d  = st_q;
    pop_s = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (count_q != 5'd0) st_d = ST_ASSERT;
        else                 st_d = ST_IDLE;
      end
      ST_ASSERT: begin
        if (ACK_WR && (count_q != 5'd0)) begin
          pop_s = 1'b1;
          st_d  = ST_IDLE;
        end else if (INTACK) begin
          st_d = ST_SERVICE;
        end else begin
          st_d = ST_ASSERT;
        end
      end
      ST_SERVICE: begin
        if (ACK_WR && (count_q != 5'd0)) begin
          pop_s = 1'b1;
          st_d  = ST_IDLE;
        end else begin
          st_d = ST_SERVICE;
        end
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  // Occupancy update: simultaneous push and pop leave the count unchanged.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

`ifdef GAREGGA_SNDCMD_FIFO_EN
  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;

  // Next head: a byte pushed into the slot that becomes the head this cycle bypasses the array.
  always_comb begin
    if (pop_s) rd_ptr_d = rd_ptr_q + PW'(1);
    else       rd_ptr_d = rd_ptr_q;
    if (push_s && (rd_ptr_d == wr_ptr_q)) head_d = CMD_DIN;
    else                                  head_d = mem_q[rd_ptr_d];
  end

  // Circular pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK96) begin
    if (!RESET96_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PW'(1);
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage needs no reset; the count qualifies every read.
  always_ff @(posedge CLK96) begin
    if (push_s) mem_q[wr_ptr_q] <= CMD_DIN;
  end
`else
  logic [7:0] data_q;

  // Single latch: the head is the incoming byte on a push into an empty latch.
  always_comb begin
    if (push_s) head_d = CMD_DIN;
    else        head_d = data_q;
  end

  // Single-entry holding register.
  always_ff @(posedge CLK96) begin
    if (!RESET96_N) data_q <= 8'h00;
    else if (push_s) data_q <= CMD_DIN;
  end
`endif

  // SOUNDLATCH tracks the head while anything is queued and holds when empty.
  always_comb begin
    if (count_d != 5'd0) latch_d = head_d;
    else                 latch_d = latch_q;
  end

  // Control state and registered outputs.
  always_ff @(posedge CLK96) begin
    if (!RESET96_N) begin
      st_q    <= ST_IDLE;
      count_q <= 5'd0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      int_n_q <= 1'b1;
      latch_q <= 8'h00;
    end else begin
      st_q    <= st_d;
      count_q <= count_d;
      busy_q  <= (count_d == CAP5);
      ovr_q   <= ovr_q | drop_s;
      int_n_q <= (st_d != ST_ASSERT);
      latch_q <= latch_d;
    end
  end

  assign CMD_BUSY   = busy_q;
  assign OVERRUN    = ovr_q;
  assign SOUNDLATCH = latch_q;
  assign Z80INT_N   = int_n_q;
  assign PENDING    = count_q;

endmodule
